vga_line_fetcher: RTL



---
 rtl/vga_line_fetcher.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/vga_line_fetcher.sv
// Streams the frame buffer from FRAME_BASE into a 16-word pixel FIFO, one single-word read at a time.
// Latency: a request is raised on the edge after IDLE sees room; a popped pixel appears one cycle after its strobe.
// Backpressure: fetching pauses while the FIFO is full, enable is low or the controller is busy.
module vga_line_fetcher #(
  parameter int                ADDR_W      = 24,
  parameter int                DATA_W      = 16,
  parameter int                FIFO_AW     = 4,
  parameter logic [ADDR_W-1:0] FRAME_BASE  = 24'h000000,
  parameter logic [ADDR_W-1:0] FRAME_WORDS = 24'd307200
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                frame_start,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_request,
  output logic                mem_n_write_enable,
  output logic [DATA_W-1:0]   mem_data_write,
  input  logic [DATA_W-1:0]   mem_data_read,
  input  logic                mem_data_ready,
  input  logic                mem_busy,
  input  logic                pixel_rd_en,
  output logic [DATA_W-1:0]   pixel_data,
  output logic                fifo_empty,
  output logic [FIFO_AW:0]    fifo_level,
  output logic                underflow
);

  localparam int               DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  state_t              state, state_nx;
  logic                start;
  logic                push;
  logic                pop;
  logic [ADDR_W-1:0]   word_cnt;
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0]   fifo_mem [DEPTH];

  // The controller bus is only ever read from.
  assign mem_n_write_enable = 1'b1;
  assign mem_data_write     = '0;
  assign fifo_empty         = (fifo_level == '0);

  // A pop is only honoured when there is data and no flush is happening in the same cycle.
  assign pop = pixel_rd_en && !fifo_empty && !frame_start;

  // Next-state logic: start a read when there is room, capture the word on data_ready, then wait for ready to drop.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    push     = 1'b0;
    case (state)
      IDLE: begin
        if (!frame_start && enable && !mem_busy && (fifo_level < DEPTH_L)) begin
          state_nx = REQ;
          start    = 1'b1;
        end
      end
      REQ: begin
        if (frame_start) begin
          // Abandon the read; whatever the controller returns this cycle is dropped.
          state_nx = RELEASE;
        end else if (mem_data_ready) begin
          state_nx = RELEASE;
          push     = 1'b1;
        end
      end
      RELEASE: begin
        if (frame_start || !mem_data_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Request line, address and frame word counter; the address is latched at request start and held through REQ.
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      mem_request <= 1'b0;
      mem_addr    <= FRAME_BASE;
      word_cnt    <= '0;
    end else begin
      if (start) begin
        mem_request <= 1'b1;
        mem_addr    <= FRAME_BASE + word_cnt;
      end
      if (push) begin
        mem_request <= 1'b0;
        if (word_cnt == FRAME_WORDS - 1'b1) begin
          word_cnt <= '0;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

  // FIFO storage; a push only happens in REQ without a flush, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_data_read;
    end
  end

  // FIFO pointers, level, registered pixel output and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      pixel_data <= '0;
      underflow  <= 1'b0;
    end else if (frame_start) begin
      // Flush keeps the last pixel on the output; only the queue and the flag are cleared.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      underflow  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        pixel_data <= fifo_mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      // Emptiness is judged before this cycle's push, so a push into an empty FIFO does not rescue a pop.
      if (pixel_rd_en && fifo_empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule
